// File: rtl/ysyx_24100006_wbu.sv
// Writeback unit: a single-entry buffer after the LSU that formats load data, selects the
// writeback source, drives the GPR write port and bypass, and counts retired instructions.
module ysyx_24100006_wbu #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_WIDTH-1:0] in_alu_res,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
    input  logic [DATA_WIDTH-1:0] in_csr_rdata,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [1:0]            in_addr_low,
    input  logic [2:0]            in_load_type,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic                  commit_err,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [63:0]           instret
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    function automatic logic [DATA_WIDTH-1:0] sext8(input logic [7:0] b);
        return {{(DATA_WIDTH-8){b[7]}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sext16(input logic [15:0] h);
        return {{(DATA_WIDTH-16){h[15]}}, h};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext8(input logic [7:0] b);
        return {{(DATA_WIDTH-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] h);
        return {{(DATA_WIDTH-16){1'b0}}, h};
    endfunction

    logic                  r_state;
    logic [63:0]           r_instret;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic                  r_rd_wen;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_full;
    logic                  w_accept;
    logic                  w_fire;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic                  w_load_err;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_err;
    logic                  w_wr_ok;

    assign w_full   = (r_state == ST_FULL);
    assign in_ready = !w_full || commit_ready;
    assign w_accept = in_valid && in_ready;
    assign w_fire   = w_full && commit_ready;

    assign w_byte = in_mem_rdata[{in_addr_low, 3'b000} +: 8];
    assign w_half = in_mem_rdata[{in_addr_low[1], 4'b0000} +: 16];

    // Alignment faults flag the entry; the data lane picked for a faulting load never reaches the GPRs.
    always_comb begin
        w_load     = '0;
        w_load_err = 1'b0;
        case (in_load_type)
            3'b000: w_load = sext8(w_byte);
            3'b100: w_load = zext8(w_byte);
            3'b001: begin
                w_load     = sext16(w_half);
                w_load_err = in_addr_low[0];
            end
            3'b101: begin
                w_load     = zext16(w_half);
                w_load_err = in_addr_low[0];
            end
            3'b010: begin
                w_load     = in_mem_rdata;
                w_load_err = (in_addr_low != 2'b00);
            end
            default: w_load_err = 1'b1;
        endcase
    end

    always_comb begin
        w_result = in_alu_res;
        case (in_wb_sel)
            WB_ALU:  w_result = in_alu_res;
            WB_MEM:  w_result = w_load;
            WB_PC4:  w_result = in_pc + DATA_WIDTH'(4);
            WB_CSR:  w_result = in_csr_rdata;
            default: w_result = in_alu_res;
        endcase
    end

    assign w_err = (in_wb_sel == WB_MEM) && w_load_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_instret <= '0;
        end else begin
            if (w_accept)
                r_state <= ST_FULL;
            else if (w_fire)
                r_state <= ST_EMPTY;
            if (w_fire)
                r_instret <= r_instret + 64'd1;
        end
    end

    // Entry payload: only loaded on accept, so it holds while stalled; reset needs only the state bit.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd     <= in_rd;
            r_rd_wen <= in_rd_wen;
            r_err    <= w_err;
            r_pc     <= in_pc;
            r_result <= w_result;
        end
    end

    assign w_wr_ok = w_full && r_rd_wen && (r_rd != '0) && !r_err;

    assign gpr_wen      = w_wr_ok && commit_ready;
    assign gpr_waddr    = r_rd;
    assign gpr_wdata    = r_result;
    assign commit_valid = w_full;
    assign commit_pc    = r_pc;
    assign commit_err   = r_err;
    assign fwd_valid    = w_wr_ok;
    assign fwd_rd       = r_rd;
    assign fwd_data     = r_result;
    assign instret      = r_instret;

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Directed bench for the writeback unit: load formatting, faults, stalls, back-to-back and reset.
module tb_ysyx_24100006_wbu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_mem_rdata;
    logic [31:0] in_csr_rdata;
    logic [31:0] in_pc;
    logic [1:0]  in_addr_low;
    logic [2:0]  in_load_type;
    logic [3:0]  in_rd;
    logic        in_rd_wen;
    logic        gpr_wen;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        commit_valid;
    logic        commit_ready;
    logic [31:0] commit_pc;
    logic        commit_err;
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [63:0] instret;

    int n_checks = 0;
    int n_fails  = 0;
    int wr_count = 0;
    logic [63:0] exp_ir = 64'd0;

    ysyx_24100006_wbu #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_sel(in_wb_sel), .in_alu_res(in_alu_res), .in_mem_rdata(in_mem_rdata),
        .in_csr_rdata(in_csr_rdata), .in_pc(in_pc), .in_addr_low(in_addr_low),
        .in_load_type(in_load_type), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_err(commit_err),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (gpr_wen) wr_count <= wr_count + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] csr, input logic [31:0] pc, input logic [1:0] al,
                         input logic [2:0] lt, input logic [3:0] rd, input logic wen);
        in_valid     = 1'b1;
        in_wb_sel    = sel;
        in_alu_res   = alu;
        in_mem_rdata = mem;
        in_csr_rdata = csr;
        in_pc        = pc;
        in_addr_low  = al;
        in_load_type = lt;
        in_rd        = rd;
        in_rd_wen    = wen;
    endtask

    // One load through an always-ready consumer; checks the formatted data then retirement.
    task automatic load_case(input string tag, input logic [1:0] al, input logic [2:0] lt,
                             input logic [31:0] exp_data);
        drive(2'd1, 32'h0, 32'h80FF7F01, 32'h0, 32'h80000100, al, lt, 4'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_wdata"}, gpr_wdata, exp_data);
        chk({tag, "_wen"}, gpr_wen, 1);
        chk({tag, "_err"}, commit_err, 0);
        tick();
        exp_ir++;
        chk({tag, "_instret"}, instret, exp_ir);
    endtask

    initial begin
        int wr_before;
        rst_n = 1'b0;
        commit_ready = 1'b0;
        in_valid = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 4'd0, 1'b0);
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_instret", instret, 0);
        chk("rst_gpr_wen", gpr_wen, 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);

        // ALU writeback
        commit_ready = 1'b1;
        drive(2'd0, 32'h12345678, 32'h0, 32'h0, 32'h80000000, 2'd0, 3'd0, 4'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("alu_commit_valid", commit_valid, 1);
        chk("alu_gpr_wen", gpr_wen, 1);
        chk("alu_waddr", gpr_waddr, 5);
        chk("alu_wdata", gpr_wdata, 32'h12345678);
        chk("alu_commit_pc", commit_pc, 32'h80000000);
        chk("alu_fwd_rd", fwd_rd, 5);
        tick();
        exp_ir = 1;
        chk("alu_instret", instret, exp_ir);
        chk("alu_drained", commit_valid, 0);

        load_case("lb", 2'd2, 3'b000, 32'hFFFFFFFF);
        load_case("lbu", 2'd2, 3'b100, 32'h000000FF);
        load_case("lh", 2'd2, 3'b001, 32'hFFFF80FF);
        load_case("lhu", 2'd0, 3'b101, 32'h00007F01);
        load_case("lb0", 2'd0, 3'b000, 32'h00000001);
        load_case("lw", 2'd0, 3'b010, 32'h80FF7F01);

        // Misaligned LW
        drive(2'd1, 32'h0, 32'h80FF7F01, 32'h0, 32'h80000200, 2'd1, 3'b010, 4'd3, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("mis_commit_valid", commit_valid, 1);
        chk("mis_commit_err", commit_err, 1);
        chk("mis_gpr_wen", gpr_wen, 0);
        chk("mis_fwd_valid", fwd_valid, 0);
        tick();
        exp_ir++;
        chk("mis_instret", instret, exp_ir);

        // Stall with CSR entry; a competing request must not be taken while blocked
        commit_ready = 1'b0;
        wr_before = wr_count;
        drive(2'd3, 32'h0, 32'h0, 32'hCAFEBABE, 32'h80000300, 2'd0, 3'd0, 4'd7, 1'b1);
        tick();
        drive(2'd0, 32'hDEAD0000, 32'h0, 32'h0, 32'h80000400, 2'd0, 3'd0, 4'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_gpr_wen", gpr_wen, 0);
            chk("stall_fwd_valid", fwd_valid, 1);
            chk("stall_fwd_data", fwd_data, 32'hCAFEBABE);
            chk("stall_commit_pc", commit_pc, 32'h80000300);
            tick();
        end
        chk("stall_instret", instret, exp_ir);
        in_valid = 1'b0;
        commit_ready = 1'b1;
        #1;
        chk("unstall_gpr_wen", gpr_wen, 1);
        chk("unstall_waddr", gpr_waddr, 7);
        tick();
        exp_ir++;
        chk("unstall_writes", wr_count - wr_before, 1);
        chk("unstall_empty", commit_valid, 0);
        chk("unstall_instret", instret, exp_ir);

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 32'h100 + i, 32'h0, 32'h0, 32'h80000000 + 32'(4 * i), 2'd0, 3'd0,
                  4'(i + 1), 1'b1);
            tick();
            chk("b2b_commit_valid", commit_valid, 1);
            chk("b2b_commit_pc", commit_pc, 32'h80000000 + 32'(4 * i));
            chk("b2b_wdata", gpr_wdata, 32'h100 + i);
            chk("b2b_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        exp_ir += 4;
        chk("b2b_instret", instret, exp_ir);

        // PC+4 wrap to rd=0
        drive(2'd2, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFC, 2'd0, 3'd0, 4'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("pc4_commit_valid", commit_valid, 1);
        chk("pc4_gpr_wen", gpr_wen, 0);
        chk("pc4_fwd_valid", fwd_valid, 0);
        chk("pc4_wdata", gpr_wdata, 32'h00000000);
        tick();
        exp_ir++;
        chk("pc4_instret", instret, exp_ir);

        // Reset while FULL and stalled
        commit_ready = 1'b0;
        drive(2'd0, 32'h55AA55AA, 32'h0, 32'h0, 32'h80000500, 2'd0, 3'd0, 4'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("prerst_full", commit_valid, 1);
        wr_before = wr_count;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_commit_valid", commit_valid, 0);
        chk("async_rst_instret", instret, 0);
        chk("async_rst_fwd_valid", fwd_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        commit_ready = 1'b1;
        tick();
        chk("rst_no_write", wr_count - wr_before, 0);
        rst_n = 1'b1;
        tick();
        chk("after_rst_instret", instret, 0);
        chk("after_rst_commit_valid", commit_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
